mcs4_axi_rom_slave: RTL and testbench
=====================================

Name: mcs4_axi_rom_slave

Overview:
AXI4 full (burst-capable) slave on the S00_AXI port of the mcs4 IP. It accepts the 32-bit INCR/FIXED/WRAP bursts driven by the PS or bus master and stores them into a 4 KiB program-memory image. It returns the same image on AXI read bursts. A second, byte-wide read port feeds the MCS-4 (4004) core's ROM fetch path.

Parameters:
C_S00_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
C_S00_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported
C_S00_AXI_ADDR_WIDTH, 12, byte address width; 4 KiB image
ROM_ADDR_WIDTH, 12, core-side byte address width

Ports:
s00_axi_aclk  in  1  single clock for all logic
s00_axi_aresetn  in  1  reset, asynchronous, active-low
s00_axi_awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awqos/awregion  in  ID/12/8/3/2/1/4/3/4/4  write address
s00_axi_awvalid  in  1; s00_axi_awready  out  1
s00_axi_wdata/wstrb/wlast  in  32/4/1; s00_axi_wvalid  in  1; s00_axi_wready  out  1
s00_axi_bid/bresp  out  ID/2; s00_axi_bvalid  out  1; s00_axi_bready  in  1
s00_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/arregion  in  ID/12/8/3/2/1/4/3/4/4  read address
s00_axi_arvalid  in  1; s00_axi_arready  out  1
s00_axi_rid/rdata/rresp/rlast  out  ID/32/2/1; s00_axi_rvalid  out  1; s00_axi_rready  in  1
rom_addr  in  12  core ROM byte address
rom_data  out  8  byte at rom_addr, registered

Behaviour:
- Clock and reset: one clock, s00_axi_aclk. Reset s00_axi_aresetn is asynchronous, active-low.
- Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp/rresp/bid/rid/rdata=0, rom_data=0. Memory contents are not reset.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch id, addr, len, size, burst; beat counter=0; go to W_DATA. awready drops the next cycle.
  - W_DATA: wready=1. Each W handshake writes the lanes enabled by wstrb to word addr[11:2].
  - Burst end is the first of wlast=1 or beat counter==len. On end, go to W_RESP.
  - If wlast disagrees with the counter, bresp=SLVERR; otherwise OKAY.
  - W_RESP: bvalid held with bid until bready, then W_IDLE with awready=1.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch the burst and issue the memory read of the first address.
  - rvalid asserts the next cycle (1-cycle latency).
  - R_DATA: rdata/rid/rlast are held stable while rvalid & !rready.
  - On each R handshake, the next address is read in the same cycle, so back-to-back beats run at full throughput.
  - rlast=1 on beat len. After the last handshake, rvalid=0 and the FSM returns to R_IDLE.
  - rresp always OKAY.
- Address generation, computed per beat with the step 2^size (size>2 is clamped to 2):
  - FIXED: address constant.
  - INCR: addr += step, modulo 4 KiB.
  - WRAP: boundary = (len+1)*step. Address wraps to the aligned base; len not in {1,3,7,15} is treated as INCR.
  - Reserved burst type (3) is treated as INCR.
- Narrow transfers: write lanes follow wstrb only; rdata is always the full word.
- Lock/cache/prot/qos/region are ignored. Exclusive access returns OKAY, never EXOKAY.
- Concurrency: read and write FSMs are independent; AW and AR may handshake in the same cycle.
- Same-word read and write in one cycle: the AXI read and rom_data return the old data (read-first).
- Core port: rom_data = byte rom_addr[1:0] (little-endian) of word rom_addr[11:2], registered, 1-cycle latency, every cycle.
- Reset mid-burst: both FSMs return to IDLE immediately. Outstanding B/R responses are dropped. Memory writes already completed persist.

Decomposition:
- Package mcs4_axi_pkg:
  - burst-type constants (FIXED=0, INCR=1, WRAP=2)
  - resp constants (OKAY=0, SLVERR=2)
  - write/read FSM state enums
  - function next_addr(addr, len, size, burst) returning the next 12-bit address
- One sub-module, mcs4_rom_mem: 1024x32 memory with one byte-enabled write port and two registered read ports (AXI read, core read), read-first.

Test Plan:
- INCR write, id 0, addr 0, len 7, data 1..8, then INCR read of the same burst -> read data equals written data, bresp=OKAY, rlast on beat 8 only.
- After the burst above, rom_addr=0x004 then 0x01C -> rom_data=0x02 then 0x08, each one cycle after the address.
- Single write to 0x010, data 0xAABBCCDD, wstrb=0101 over a prior 0x11223344 -> read of 0x010 returns 0x11BB33DD.
- WRAP read, araddr 0x008, len 3 -> words read from 0x008, 0x00C, 0x000, 0x004. FIXED read, len 3, addr 0x004 -> the same word returned four times.
- INCR read len 7 with rready toggling 1,0,0,1,... -> rdata/rlast stable while stalled, no beat lost or duplicated. INCR write len 7 with wlast asserted on beat 4 -> burst ends, bresp=SLVERR, awready=1 again.
- Deassert s00_axi_aresetn during beat 3 of an 8-beat read -> rvalid=0 immediately; after release a new read to 0x000 completes normally and words 0..2 of the earlier write still hold 1..3.

Source files
------------

// File: rtl/mcs4_axi_pkg.sv
// Shared types, constants and burst address arithmetic for the mcs4 S00_AXI ROM slave.
package mcs4_axi_pkg;

  localparam int unsigned ADDR_W = 12;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Address of the beat after addr; sizes above 4 bytes clamp to a 4-byte step,
  // illegal WRAP lengths and the reserved burst type behave as INCR.
  function automatic addr_t next_addr(input addr_t addr, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    logic [1:0] sz;
    addr_t      step;
    addr_t      incr;
    addr_t      mask;
    addr_t      result;
    sz     = (size > 3'd2) ? 2'd2 : size[1:0];
    step   = addr_t'(1) << sz;
    incr   = addr + step;
    mask   = ((addr_t'(len) + addr_t'(1)) << sz) - addr_t'(1);
    case (burst)
      BURST_FIXED: result = addr;
      BURST_WRAP: begin
        if (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)
          result = (addr & ~mask) | (incr & mask);
        else
          result = incr;
      end
      default: result = incr;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mcs4_axi_if.sv
// AXI4 full channel bundle for the S00_AXI port of the mcs4 IP.
interface mcs4_axi_if #(
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/mcs4_rom_mem.sv
// Program-memory image: one byte-enabled write port, registered word read (AXI)
// and registered byte read (core), both read-first against a same-cycle write.
module mcs4_rom_mem #(
  parameter int unsigned WORD_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BYTE_ADDR_WIDTH = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [WORD_ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH/8-1:0]    wstrb,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       ren_a,
  input  logic [WORD_ADDR_WIDTH-1:0] raddr_a,
  output logic [DATA_WIDTH-1:0]      rdata_a,
  input  logic [BYTE_ADDR_WIDTH-1:0] addr_b,
  output logic [7:0]                 rdata_b
);
  localparam int unsigned LANES     = DATA_WIDTH / 8;
  localparam int unsigned LANE_BITS = $clog2(LANES);

  logic [DATA_WIDTH-1:0] mem [2**WORD_ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] word_b;
  logic [LANE_BITS-1:0]  lane_b;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign word_b = mem[addr_b[BYTE_ADDR_WIDTH-1:LANE_BITS]];
  assign lane_b = addr_b[LANE_BITS-1:0];

  // Read registers are reset; the array itself deliberately is not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (ren_a) rdata_a <= mem[raddr_a];
      rdata_b <= word_b[8*lane_b +: 8];
    end
  end

endmodule

// File: rtl/mcs4_axi_rom_slave.sv
// AXI4 burst slave over the 4 KiB mcs4 program image, with a byte-wide fetch port
// for the 4004 core. Read and write channels run as independent FSMs.
module mcs4_axi_rom_slave
  import mcs4_axi_pkg::*;
#(
  parameter int unsigned C_S00_AXI_ID_WIDTH   = 1,
  parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S00_AXI_ADDR_WIDTH = 12,
  parameter int unsigned ROM_ADDR_WIDTH       = 12
) (
  input  logic                      s00_axi_aclk,
  input  logic                      s00_axi_aresetn,
  mcs4_axi_if.slave                 s00_axi,
  input  logic [ROM_ADDR_WIDTH-1:0] rom_addr,
  output logic [7:0]                rom_data
);
  localparam int unsigned WORD_AW = C_S00_AXI_ADDR_WIDTH - 2;

  w_state_e                      w_state, w_next;
  logic [C_S00_AXI_ID_WIDTH-1:0] aw_id;
  addr_t                         aw_addr;
  logic [7:0]                    aw_len;
  logic [2:0]                    aw_size;
  logic [1:0]                    aw_burst;
  logic [7:0]                    w_cnt;
  logic [1:0]                    b_resp;
  logic                          aw_hs, w_hs, w_end;

  r_state_e                      r_state, r_next;
  logic [C_S00_AXI_ID_WIDTH-1:0] ar_id;
  addr_t                         r_addr;
  logic [7:0]                    ar_len;
  logic [2:0]                    ar_size;
  logic [1:0]                    ar_burst;
  logic [7:0]                    r_cnt;
  logic                          r_last;
  logic                          ar_hs, r_hs;
  logic                          mem_ren;
  logic [WORD_AW-1:0]            mem_raddr;
  logic [C_S00_AXI_DATA_WIDTH-1:0] rd_word;

  // ---------------- write channel ----------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) w_state <= W_IDLE;
    else                  w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    aw_hs  = 1'b0;
    w_hs   = 1'b0;
    w_end  = 1'b0;
    case (w_state)
      W_IDLE: if (s00_axi.awvalid) begin
        aw_hs  = 1'b1;
        w_next = W_DATA;
      end
      W_DATA: if (s00_axi.wvalid) begin
        w_hs  = 1'b1;
        w_end = s00_axi.wlast || (w_cnt == aw_len);
        if (w_end) w_next = W_RESP;
      end
      W_RESP: if (s00_axi.bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_len   <= '0;
      aw_size  <= '0;
      aw_burst <= '0;
      w_cnt    <= '0;
      b_resp   <= RESP_OKAY;
    end else if (aw_hs) begin
      aw_id    <= s00_axi.awid;
      aw_addr  <= s00_axi.awaddr;
      aw_len   <= s00_axi.awlen;
      aw_size  <= s00_axi.awsize;
      aw_burst <= s00_axi.awburst;
      w_cnt    <= '0;
    end else if (w_hs) begin
      aw_addr <= next_addr(aw_addr, aw_len, aw_size, aw_burst);
      w_cnt   <= w_cnt + 8'd1;
      // A wlast that disagrees with the beat count still ends the burst, but flags it.
      if (w_end) b_resp <= (s00_axi.wlast != (w_cnt == aw_len)) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign s00_axi.awready = (w_state == W_IDLE);
  assign s00_axi.wready  = (w_state == W_DATA);
  assign s00_axi.bvalid  = (w_state == W_RESP);
  assign s00_axi.bresp   = b_resp;
  assign s00_axi.bid     = aw_id;

  // ---------------- read channel ----------------
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) r_state <= R_IDLE;
    else                  r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    ar_hs  = 1'b0;
    r_hs   = 1'b0;
    case (r_state)
      R_IDLE: if (s00_axi.arvalid) begin
        ar_hs  = 1'b1;
        r_next = R_DATA;
      end
      R_DATA: if (s00_axi.rready) begin
        r_hs = 1'b1;
        if (r_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // r_addr always holds the address of the beat after the one being presented,
  // so a handshake can launch the next memory read in the same cycle.
  assign mem_ren   = ar_hs || (r_hs && !r_last);
  assign mem_raddr = ar_hs ? s00_axi.araddr[ADDR_W-1:2] : r_addr[ADDR_W-1:2];

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      ar_id    <= '0;
      r_addr   <= '0;
      ar_len   <= '0;
      ar_size  <= '0;
      ar_burst <= '0;
      r_cnt    <= '0;
      r_last   <= 1'b0;
    end else if (ar_hs) begin
      ar_id    <= s00_axi.arid;
      r_addr   <= next_addr(s00_axi.araddr, s00_axi.arlen, s00_axi.arsize, s00_axi.arburst);
      ar_len   <= s00_axi.arlen;
      ar_size  <= s00_axi.arsize;
      ar_burst <= s00_axi.arburst;
      r_cnt    <= '0;
      r_last   <= (s00_axi.arlen == 8'd0);
    end else if (r_hs) begin
      if (r_last) begin
        r_last <= 1'b0;
      end else begin
        r_addr <= next_addr(r_addr, ar_len, ar_size, ar_burst);
        r_cnt  <= r_cnt + 8'd1;
        r_last <= ((r_cnt + 8'd1) == ar_len);
      end
    end
  end

  assign s00_axi.arready = (r_state == R_IDLE);
  assign s00_axi.rvalid  = (r_state == R_DATA);
  assign s00_axi.rlast   = r_last;
  assign s00_axi.rid     = ar_id;
  assign s00_axi.rresp   = RESP_OKAY;
  assign s00_axi.rdata   = rd_word;

  mcs4_rom_mem #(
    .WORD_ADDR_WIDTH (WORD_AW),
    .DATA_WIDTH      (C_S00_AXI_DATA_WIDTH),
    .BYTE_ADDR_WIDTH (ROM_ADDR_WIDTH)
  ) u_mem (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .we      (w_hs),
    .waddr   (aw_addr[ADDR_W-1:2]),
    .wstrb   (s00_axi.wstrb),
    .wdata   (s00_axi.wdata),
    .ren_a   (mem_ren),
    .raddr_a (mem_raddr),
    .rdata_a (rd_word),
    .addr_b  (rom_addr),
    .rdata_b (rom_data)
  );

  logic unused_attrs;
  assign unused_attrs = ^{s00_axi.awlock, s00_axi.awcache, s00_axi.awprot, s00_axi.awqos,
                          s00_axi.awregion, s00_axi.arlock, s00_axi.arcache, s00_axi.arprot,
                          s00_axi.arqos, s00_axi.arregion};

endmodule

// File: tb/tb_mcs4_axi_rom_slave.sv
// Scoreboard bench for mcs4_axi_rom_slave: directed bursts push expected B/R responses,
// a monitor pops and compares them whenever the DUT presents a response.
module tb_mcs4_axi_rom_slave;

  localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3;
  localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2;

  typedef struct packed { logic [0:0] id; logic [1:0] resp; } bexp_t;
  typedef struct packed { logic [0:0] id; logic last; logic [31:0] data; } rexp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;

  int checks = 0;
  int failures = 0;

  bexp_t exp_b[$];
  rexp_t exp_r[$];

  mcs4_axi_if #(.ID_WIDTH(1), .ADDR_WIDTH(12), .DATA_WIDTH(32)) ifc ();

  mcs4_axi_rom_slave #(
    .C_S00_AXI_ID_WIDTH   (1),
    .C_S00_AXI_DATA_WIDTH (32),
    .C_S00_AXI_ADDR_WIDTH (12),
    .ROM_ADDR_WIDTH       (12)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi         (ifc.slave),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm, input string what);
    checks++;
    failures++;
    $display("FAIL %s %s", nm, what);
  endtask

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    bexp_t be;
    rexp_t re;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ifc.bvalid && ifc.bready) begin
          if (exp_b.size() == 0) fail_now("b_unexpected", "actual=bvalid required=idle");
          else begin
            be = exp_b.pop_front();
            check("bresp", {ifc.bid, ifc.bresp}, {be.id, be.resp});
          end
        end
        if (ifc.rvalid) begin
          if (exp_r.size() == 0) fail_now("r_unexpected", "actual=rvalid required=idle");
          else begin
            re = exp_r[0];
            check(ifc.rready ? "rbeat" : "rstall",
                  {ifc.rid, ifc.rresp, ifc.rlast, ifc.rdata}, {re.id, OKAY, re.last, re.data});
            if (ifc.rready) void'(exp_r.pop_front());
          end
        end
      end
    end
  end

  task automatic wait_ready(input int unsigned sel, input string nm);
    logic got;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      case (sel)
        0:       got = ifc.awready;
        1:       got = ifc.wready;
        default: got = ifc.arready;
      endcase
      if (got) break;
    end
    if (!got) fail_now(nm, "actual=no_ready required=ready");
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      fail_now("drain_timeout", "actual=pending required=empty");
      exp_r.delete();
      exp_b.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [0:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                           input int last_at, input logic [1:0] resp);
    int nbeats;
    exp_b.push_back('{id: id, resp: resp});
    ifc.awid = id; ifc.awaddr = addr; ifc.awlen = len; ifc.awsize = 3'd2; ifc.awburst = burst;
    ifc.awvalid = 1'b1;
    wait_ready(0, "aw_timeout");
    ifc.awvalid = 1'b0;
    nbeats = (last_at >= 0) ? last_at + 1 : int'(len) + 1;
    for (int i = 0; i < nbeats; i++) begin
      ifc.wdata  = d0 + 32'(i);
      ifc.wstrb  = strb;
      ifc.wlast  = (i == last_at);
      ifc.wvalid = 1'b1;
      wait_ready(1, "w_timeout");
    end
    ifc.wvalid = 1'b0;
    ifc.wlast  = 1'b0;
    wait_drain();
  endtask

  task automatic exp_read(input logic [0:0] id, input logic [31:0] data, input logic last);
    exp_r.push_back('{id: id, last: last, data: data});
  endtask

  task automatic ar_send(input logic [0:0] id, input logic [11:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    ifc.arid = id; ifc.araddr = addr; ifc.arlen = len; ifc.arsize = 3'd2; ifc.arburst = burst;
    ifc.arvalid = 1'b1;
    wait_ready(2, "ar_timeout");
    ifc.arvalid = 1'b0;
  endtask

  task automatic rom_check(input logic [11:0] a, input logic [7:0] req, input string nm);
    rom_addr = a;
    @(posedge clk); #1;
    check(nm, rom_data, req);
  endtask

  function automatic logic [31:0] img(input int i);
    return (i == 4) ? 32'h11BB33DD : 32'(i + 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] pat;
    pat = 4'b1001;
    rom_addr = '0;
    ifc.awid = '0; ifc.awaddr = '0; ifc.awlen = '0; ifc.awsize = '0; ifc.awburst = '0;
    ifc.awlock = '0; ifc.awcache = '0; ifc.awprot = '0; ifc.awqos = '0; ifc.awregion = '0;
    ifc.awvalid = 1'b0;
    ifc.wdata = '0; ifc.wstrb = '0; ifc.wlast = 1'b0; ifc.wvalid = 1'b0;
    ifc.bready = 1'b1;
    ifc.arid = '0; ifc.araddr = '0; ifc.arlen = '0; ifc.arsize = '0; ifc.arburst = '0;
    ifc.arlock = '0; ifc.arcache = '0; ifc.arprot = '0; ifc.arqos = '0; ifc.arregion = '0;
    ifc.arvalid = 1'b0;
    ifc.rready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_data", rom_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", {ifc.awready, ifc.arready, ifc.wready}, 3'b110);
    check("rst_valid", {ifc.bvalid, ifc.rvalid, ifc.rlast}, 3'b000);
    check("rst_ids", {ifc.bid, ifc.bresp, ifc.rid, ifc.rresp}, 6'd0);
    check("rst_rdata", ifc.rdata, 32'h0);

    // INCR write 1..8 then read back
    axi_write(1'b0, 12'h000, 8'd7, INCR, 32'd1, 4'hF, 7, OKAY);
    for (int i = 0; i < 8; i++) exp_read(1'b0, 32'(i + 1), i == 7);
    ar_send(1'b0, 12'h000, 8'd7, INCR);
    wait_drain();

    // Core byte port, including one-cycle latency
    rom_check(12'h004, 8'h02, "rom_004");
    rom_addr = 12'h01C;
    #1;
    check("rom_latency", rom_data, 8'h02);
    @(posedge clk); #1;
    check("rom_01c", rom_data, 8'h08);

    // Partial-strobe overwrite
    axi_write(1'b1, 12'h010, 8'd0, INCR, 32'h11223344, 4'hF, 0, OKAY);
    axi_write(1'b1, 12'h010, 8'd0, INCR, 32'hAABBCCDD, 4'b0101, 0, OKAY);
    exp_read(1'b1, 32'h11BB33DD, 1'b1);
    ar_send(1'b1, 12'h010, 8'd0, INCR);
    wait_drain();
    rom_check(12'h011, 8'h33, "rom_011");
    rom_check(12'h013, 8'h11, "rom_013");

    // WRAP len 3 from 0x008: 0x008, 0x00C, 0x000, 0x004
    exp_read(1'b0, 32'd3, 1'b0); exp_read(1'b0, 32'd4, 1'b0);
    exp_read(1'b0, 32'd1, 1'b0); exp_read(1'b0, 32'd2, 1'b1);
    ar_send(1'b0, 12'h008, 8'd3, WRAP);
    wait_drain();

    // FIXED len 3 at 0x004
    for (int i = 0; i < 4; i++) exp_read(1'b0, 32'd2, i == 3);
    ar_send(1'b0, 12'h004, 8'd3, FIXED);
    wait_drain();

    // INCR len 7 with rready 1,0,0,1,...
    for (int i = 0; i < 8; i++) exp_read(1'b1, img(i), i == 7);
    ar_send(1'b1, 12'h000, 8'd7, INCR);
    n = 0;
    while (exp_r.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      ifc.rready = pat[n % 4];
      n++;
    end
    ifc.rready = 1'b1;
    if (n >= 200) fail_now("stall_timeout", "actual=pending required=empty");
    wait_drain();

    // Early wlast on beat index 3 of len 7
    axi_write(1'b0, 12'h100, 8'd7, INCR, 32'hA0, 4'hF, 3, SLVERR);
    check("awready_after_slverr", {ifc.awready, ifc.wready}, 2'b10);
    for (int i = 0; i < 4; i++) exp_read(1'b0, 32'hA0 + 32'(i), i == 3);
    ar_send(1'b0, 12'h100, 8'd3, INCR);
    wait_drain();

    // Missing wlast: ends on count, flagged
    axi_write(1'b1, 12'h200, 8'd1, INCR, 32'hB0, 4'hF, -1, SLVERR);
    check("awready_after_nolast", {ifc.awready, ifc.wready}, 2'b10);

    // Reset during beat 3 of an 8-beat read
    for (int i = 0; i < 8; i++) exp_read(1'b0, img(i), i == 7);
    ar_send(1'b0, 12'h000, 8'd7, INCR);
    n = 0;
    while (exp_r.size() > 5 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) fail_now("mid_reset_timeout", "actual=pending required=beat3");
    rst_n = 1'b0;
    #1;
    check("mid_reset_rvalid", {ifc.rvalid, ifc.rlast}, 2'b00);
    check("mid_reset_ready", {ifc.arready, ifc.awready}, 2'b11);
    exp_r.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) exp_read(1'b0, 32'(i + 1), i == 2);
    ar_send(1'b0, 12'h000, 8'd2, INCR);
    wait_drain();

    // INCR crossing the top of the 4 KiB image wraps to 0x000
    axi_write(1'b0, 12'hFFC, 8'd1, INCR, 32'h55, 4'hF, 1, OKAY);
    exp_read(1'b0, 32'h55, 1'b0); exp_read(1'b0, 32'h56, 1'b1);
    ar_send(1'b0, 12'hFFC, 8'd1, INCR);
    wait_drain();
    rom_check(12'h000, 8'h56, "rom_000_wrapped");

    // WRAP with len 2 behaves as INCR; reserved burst type behaves as INCR
    exp_read(1'b1, 32'd3, 1'b0); exp_read(1'b1, 32'd4, 1'b0); exp_read(1'b1, 32'h11BB33DD, 1'b1);
    ar_send(1'b1, 12'h008, 8'd2, WRAP);
    wait_drain();
    exp_read(1'b0, 32'd6, 1'b0); exp_read(1'b0, 32'd7, 1'b1);
    ar_send(1'b0, 12'h014, 8'd1, RSVD);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
